// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: captures a six-entry code table, then packs symbol codes
// MSB-first into a byte stream, zero-padding and flagging the last byte of each frame.
module huffman_bit_packer #(
  parameter int NSYM   = 6,
  parameter int MAXLEN = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_last,
  output logic       sym_ready,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_last,
  input  logic       byte_ready,
  output logic       sym_err,
  output logic       table_loaded
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      r_state;
  logic [7:0]  r_hc   [NSYM];
  logic [7:0]  r_mask [NSYM];
  logic [15:0] r_acc;
  logic [4:0]  r_bitCnt;
  logic        r_byteValid;
  logic [7:0]  r_byteData;
  logic        r_byteLast;
  logic        r_symErr;
  logic        r_tableLoaded;

  logic [7:0]  w_hcIn   [NSYM];
  logic [7:0]  w_maskIn [NSYM];
  logic [7:0]  w_code;
  logic [7:0]  w_mask;
  logic        w_match;
  logic [3:0]  w_ones;
  logic [3:0]  w_len;
  logic        w_legal;
  logic        w_symReady;
  logic        w_accept;
  logic        w_append;
  logic        w_byteFree;
  logic        w_load;
  logic [4:0]  w_drain;
  logic [4:0]  w_cntDrained;
  logic [15:0] w_accDrained;
  logic [15:0] w_codeAligned;
  logic [15:0] w_accNext;
  logic [4:0]  w_cntNext;

  assign w_hcIn   = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign w_maskIn = '{M1, M2, M3, M4, M5, M6};

  // Table lookup for the presented symbol; values outside 1..NSYM find no entry.
  always_comb begin
    w_code  = '0;
    w_mask  = '0;
    w_match = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (sym_data == 8'(i + 1)) begin
        w_code  = r_hc[i];
        w_mask  = r_mask[i];
        w_match = 1'b1;
      end
    end
  end

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 8; i++) begin
      w_ones = w_ones + {3'b000, w_mask[i]};
    end
    w_len = (w_ones > 4'(MAXLEN)) ? 4'(MAXLEN) : w_ones;
  end

  assign w_legal    = w_match && (w_mask != 8'h00);
  assign w_symReady = (r_state == RUN) && (r_bitCnt <= 5'd8);
  assign w_accept   = sym_valid && w_symReady;
  assign w_append   = w_accept && w_legal;
  assign w_byteFree = !r_byteValid || byte_ready;
  assign w_load     = w_byteFree &&
                      (((r_state == RUN) && (r_bitCnt >= 5'd8)) ||
                       ((r_state == FLUSH) && (r_bitCnt != 5'd0)));

  // Accumulator is left-aligned: drain from the top first, then append the
  // new code directly beneath whatever bits remain.
  assign w_drain       = !w_load ? 5'd0 : ((r_bitCnt >= 5'd8) ? 5'd8 : r_bitCnt);
  assign w_cntDrained  = r_bitCnt - w_drain;
  assign w_accDrained  = r_acc << w_drain;
  assign w_codeAligned = ({w_code, 8'h00} << (4'd8 - w_len)) >> w_cntDrained;
  assign w_accNext     = w_append ? (w_accDrained | w_codeAligned) : w_accDrained;
  assign w_cntNext     = w_cntDrained + (w_append ? {1'b0, w_len} : 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSYM; i++) begin
        r_hc[i]   <= '0;
        r_mask[i] <= '0;
      end
      r_tableLoaded <= 1'b0;
    end else if (code_valid) begin
      for (int i = 0; i < NSYM; i++) begin
        r_hc[i]   <= w_hcIn[i];
        r_mask[i] <= w_maskIn[i];
      end
      r_tableLoaded <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_bitCnt    <= '0;
      r_byteValid <= 1'b0;
      r_byteData  <= '0;
      r_byteLast  <= 1'b0;
      r_symErr    <= 1'b0;
    end else begin
      r_acc    <= w_accNext;
      r_bitCnt <= w_cntNext;
      r_symErr <= w_accept && !w_legal;

      if (w_load) begin
        r_byteValid <= 1'b1;
        r_byteData  <= r_acc[15:8];
        r_byteLast  <= (r_state == FLUSH) && (r_bitCnt <= 5'd8);
      end else if (byte_ready) begin
        r_byteValid <= 1'b0;
        r_byteLast  <= 1'b0;
      end

      // A frame that contributed no bits leaves FLUSH as soon as nothing is pending.
      case (r_state)
        IDLE:    if (code_valid) r_state <= RUN;
        RUN:     if (w_accept && sym_last) r_state <= FLUSH;
        FLUSH:   if ((r_byteValid && byte_ready && r_byteLast) ||
                     ((r_bitCnt == 5'd0) && !r_byteValid)) r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sym_ready    = w_symReady;
  assign byte_valid   = r_byteValid;
  assign byte_data    = r_byteData;
  assign byte_last    = r_byteLast;
  assign sym_err      = r_symErr;
  assign table_loaded = r_tableLoaded;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Scoreboard bench for huffman_bit_packer: a bit-queue reference model predicts
// the byte stream while a negedge monitor checks every presented byte.
module tb_huffman_bit_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] HC1 = '0, HC2 = '0, HC3 = '0, HC4 = '0, HC5 = '0, HC6 = '0;
  logic [7:0] M1 = '0, M2 = '0, M3 = '0, M4 = '0, M5 = '0, M6 = '0;
  logic       sym_valid = 1'b0;
  logic [7:0] sym_data = '0;
  logic       sym_last = 1'b0;
  logic       sym_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready = 1'b0;
  logic       sym_err;
  logic       table_loaded;

  huffman_bit_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
    .sym_ready(sym_ready), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .sym_err(sym_err),
    .table_loaded(table_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t expQ[$];
  bit   modelBits[$];
  int   errors = 0;
  int   checks = 0;
  int   readyMode = 0;

  logic [7:0] tblHc [1:6] = '{8'h01, 8'h00, 8'h03, 8'h04, 8'h0B, 8'h0A};
  logic [7:0] tblM  [1:6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushByte(input bit isLast);
    logic [7:0] b = '0;
    for (int k = 7; k >= 0; k--) begin
      if (modelBits.size() > 0) b[k] = modelBits.pop_front();
    end
    expQ.push_back('{data: b, last: isLast});
  endtask

  // Reference model: codes become a plain bit list; bytes are cut from its front.
  task automatic modelAccept(input int sym, input bit last);
    if (sym >= 1 && sym <= 6 && tblM[sym] != 8'h00) begin
      int len = $countones(tblM[sym]);
      for (int b = len - 1; b >= 0; b--) modelBits.push_back(tblHc[sym][b]);
    end
    if (last) begin
      while (modelBits.size() > 0) pushByte(modelBits.size() <= 8);
    end else begin
      while (modelBits.size() >= 8) pushByte(1'b0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every presented byte must match the head of the queue, held or not.
  always @(negedge clk) begin
    if (!reset && byte_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected byte: got 0x%0h last=%0b, expected none",
                 byte_data, byte_last);
      end else begin
        checkOutput("byte_data", 32'(byte_data), 32'(expQ[0].data));
        checkOutput("byte_last", 32'(byte_last), 32'(expQ[0].last));
        if (byte_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic loadTable();
    code_valid = 1'b1;
    HC1 = tblHc[1]; HC2 = tblHc[2]; HC3 = tblHc[3];
    HC4 = tblHc[4]; HC5 = tblHc[5]; HC6 = tblHc[6];
    M1 = tblM[1]; M2 = tblM[2]; M3 = tblM[3];
    M4 = tblM[4]; M5 = tblM[5]; M6 = tblM[6];
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int sym, input bit last);
    int  budget = 300;
    bit  done = 0;
    bit  rdy;
    bit  illegal = !(sym >= 1 && sym <= 6);
    sym_valid = 1'b1;
    sym_data  = 8'(sym);
    sym_last  = last;
    while (!done && budget > 0) begin
      rdy = sym_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        modelAccept(sym, last);
      end
      @(negedge clk);
      budget--;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: symbol %0d not accepted, expected accept", sym);
    end else begin
      checkOutput("sym_err", 32'(sym_err), 32'(illegal));
    end
  endtask

  task automatic waitDrain(input string name);
    int budget = 3000;
    while ((expQ.size() != 0 || byte_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain timeout: %0d bytes outstanding, expected 0", name, expQ.size());
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput({name, " back to RUN"}, 32'(sym_ready), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " sym_ready"}, 32'(sym_ready), 32'd0);
    checkOutput({name, " byte_valid"}, 32'(byte_valid), 32'd0);
    checkOutput({name, " byte_data"}, 32'(byte_data), 32'd0);
    checkOutput({name, " byte_last"}, 32'(byte_last), 32'd0);
    checkOutput({name, " sym_err"}, 32'(sym_err), 32'd0);
    checkOutput({name, " table_loaded"}, 32'(table_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int illegalSyms [4] = '{0, 7, 9, 255};
    repeat (2) @(negedge clk);
    checkIdleOutputs("in reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("idle no table");
    loadTable();
    checkOutput("table_loaded", 32'(table_loaded), 32'd1);
    checkOutput("sym_ready after load", 32'(sym_ready), 32'd1);

    readyMode = 1;
    applyStimulus(1, 0); applyStimulus(2, 0); applyStimulus(3, 0); applyStimulus(4, 1);
    waitDrain("frame 1234");
    applyStimulus(5, 0); applyStimulus(6, 1);
    waitDrain("frame 56");
    for (int i = 0; i < 8; i++) applyStimulus(1, i == 7);
    waitDrain("eight ones");
    applyStimulus(1, 0); applyStimulus(7, 0); applyStimulus(2, 1);
    waitDrain("illegal mid");
    applyStimulus(7, 1);
    waitDrain("all illegal");

    // Backpressure: the accumulator fills until the accept guard closes.
    readyMode = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(5, 0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("sym_ready backpressure", 32'(sym_ready), 32'd0);
    end
    readyMode = 1;
    for (int i = 0; i < 4; i++) applyStimulus(5, i == 3);
    waitDrain("backpressure");

    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(1, 10);
      readyMode = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) begin
        int sym = $urandom_range(1, 6);
        bit last = (i == n - 1);
        if (!last && $urandom_range(0, 7) == 0) sym = illegalSyms[$urandom_range(0, 3)];
        applyStimulus(sym, last);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      waitDrain("random frame");
    end

    // Reset mid-frame with bits pending.
    readyMode = 1;
    applyStimulus(1, 0); applyStimulus(2, 0); applyStimulus(3, 0);
    reset = 1'b1;
    expQ.delete();
    modelBits.delete();
    @(negedge clk);
    checkIdleOutputs("mid-frame reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("after reset");
    loadTable();
    applyStimulus(1, 0); applyStimulus(2, 1);
    waitDrain("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream consumer of the Huffman code generator.
- Captures the six-entry code table (HC1..HC6 / M1..M6) on the code_valid pulse.
- Re-reads a gray-level symbol stream and packs the variable-length codes MSB-first into an 8-bit byte stream with valid/ready handshakes on both sides.
- Final partial byte of a frame is zero-padded and flagged with byte_last.

Parameters:
- NSYM, 6, number of table entries; symbol values 1..NSYM are legal.
- MAXLEN, 7, maximum code length in bits; the accumulator is 16 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- code_valid  in  1  one-cycle pulse; table inputs are valid this cycle.
- HC1..HC6  in  8 each  code bits, right-aligned (code LSB at bit 0).
- M1..M6  in  8 each  mask of contiguous ones from bit 0; code length = number of ones.
- sym_valid  in  1  symbol present.
- sym_data  in  8  symbol value.
- sym_last  in  1  final symbol of the frame.
- sym_ready  out  1  block can accept a symbol.
- byte_valid  out  1  byte_data holds a byte.
- byte_data  out  8  packed byte; the first code bit is at bit 7.
- byte_last  out  1  byte holds the frame's final bit.
- byte_ready  in  1  downstream accepts the byte.
- sym_err  out  1  one-cycle pulse when an illegal symbol is consumed.
- table_loaded  out  1  a table has been captured since reset.

Behaviour:
- Reset values:
  - All outputs 0.
  - Table registers 0; accumulator and bit count 0.
  - State IDLE.
- Table capture:
  - On any edge with code_valid=1, latch all HC and M inputs and set table_loaded.
  - Capture is allowed in every state.
  - Bits already in the accumulator are unaffected; later symbols use the new table.
- States:
  - IDLE: sym_ready=0. Go to RUN on the edge that captures a table.
  - RUN: accept symbols. Go to FLUSH on the edge that accepts a symbol with sym_last=1.
  - FLUSH: sym_ready=0. Drain the accumulator. Return to RUN on the edge where a byte with byte_last=1 is handed over (byte_valid & byte_ready).
- Symbol accept:
  - sym_ready = (state==RUN) & (bit_cnt <= 8).
  - Accept occurs when sym_valid & sym_ready.
- Legal symbol:
  - sym_data in 1..6 and its mask is nonzero.
  - len = popcount(M).
  - Code bits HC[len-1..0] are appended below the existing accumulator bits, MSB-first.
  - bit_cnt increases by len.
- Illegal symbol:
  - Consumed, no bits appended, sym_err pulses on the following cycle.
  - sym_last on an illegal symbol still moves the block to FLUSH.
- Byte register:
  - Loads when it is free (!byte_valid | byte_ready) and either:
    - state==RUN and bit_cnt >= 8, or
    - state==FLUSH and bit_cnt > 0.
  - On load, byte_data = top 8 accumulator bits, zero-filled below bit_cnt when bit_cnt < 8.
  - On load, bit_cnt decreases by min(8, bit_cnt).
  - In FLUSH, byte_last = (bit_cnt <= 8) at load.
  - byte_valid clears on handshake with no new load.
- Simultaneous accept and drain in one edge: bit_cnt_next = bit_cnt + len - 8. The append is positioned after the drained bits.
- Bounds:
  - bit_cnt never exceeds 15; the accept guard guarantees this.
  - After a legal last symbol bit_cnt >= 1, so every frame ends with exactly one byte_last byte.
  - An all-illegal frame with bit_cnt=0 in FLUSH returns to RUN the next cycle with no output.
- Latency:
  - Accept at edge t that makes bit_cnt >= 8 → byte_valid high after edge t+1, if the byte register is free.
  - Output is held stable while byte_valid & !byte_ready.
- Reset mid-frame: everything clears immediately, including the table; a new code_valid is required.

Test Plan:
- Use this table for all scenarios:
  - 1 = "1" (HC=01, M=01)
  - 2 = "00" (HC=00, M=03)
  - 3 = "011" (HC=03, M=07)
  - 4 = "0100" (HC=04, M=0F)
  - 5 = "01011" (HC=0B, M=1F)
  - 6 = "01010" (HC=0A, M=1F)
- Symbols 1,2,3,4 (last on 4), byte_ready=1 → bytes 0x8D (last=0) then 0x00 (last=1); back to RUN.
- Symbols 5,6 (last) → 0x5A (last=0), 0x80 (last=1).
- Eight symbol-1s, last on the 8th → single byte 0xFF with last=1. No extra padding byte.
- Repeated 5s with byte_ready=0 → sym_ready drops once bit_cnt > 8; byte_data holds 0x5A stable. On release, the stream continues 0x5A, 0xD6, 0xB5, ... with no loss.
- Stream 1,0x07,2 (last) → sym_err pulses once; output 0x80 with last=1, identical to stream 1,2.
- Assert reset during a RUN frame with bits pending → all outputs 0 and sym_ready=0 until the next code_valid; the next frame encodes correctly from an empty accumulator.
